// File: rtl/gtech_cell_bist.sv
// Exhaustive 4-input cell tester: walks patterns 0..15 onto A-D, samples Z_IN
// at the end of each hold window and compares against EXP_TT.
module gtech_cell_bist #(
    parameter logic [15:0] EXP_TT = 16'h7770,
    parameter int          SETTLE = 1
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       Z_IN,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERRCNT,
    output logic [3:0] FAILIDX,
    output logic       FAILV
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] LAST_HOLD = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic [3:0] pat;
    logic       start_run;
    logic       sample;
    logic       mism;
    logic [4:0] errcnt_nx;

    assign {D, C, B, A} = pat;

    // Control strobes and next-state decode
    always_comb begin
        state_nx  = state;
        start_run = 1'b0;
        sample    = 1'b0;
        mism      = 1'b0;
        errcnt_nx = ERRCNT;
        case (state)
            S_IDLE: begin
                if (START) begin
                    start_run = 1'b1;
                    state_nx  = S_RUN;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    // abort wins over a coincident final sample
                    state_nx = S_IDLE;
                end else if (cnt == LAST_HOLD) begin
                    sample    = 1'b1;
                    mism      = (Z_IN != EXP_TT[idx]);
                    errcnt_nx = ERRCNT + 5'(mism);
                    if (idx == 4'd15) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (START) begin
                    start_run = 1'b1;
                    state_nx  = S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CP) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Pattern walk, settle timing and result registers
    always_ff @(posedge CP) begin
        if (RST) begin
            idx     <= '0;
            cnt     <= '0;
            pat     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
            ERRCNT  <= '0;
            FAILIDX <= '0;
            FAILV   <= 1'b0;
        end else if (start_run) begin
            idx     <= '0;
            cnt     <= '0;
            pat     <= '0;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
            ERRCNT  <= '0;
            FAILIDX <= '0;
            FAILV   <= 1'b0;
        end else if (state == S_RUN) begin
            if (ABORT) begin
                // partial error results are kept for inspection
                idx  <= '0;
                cnt  <= '0;
                pat  <= '0;
                BUSY <= 1'b0;
            end else if (sample) begin
                ERRCNT <= errcnt_nx;
                if (mism && !FAILV) begin
                    FAILIDX <= idx;
                    FAILV   <= 1'b1;
                end
                cnt <= '0;
                if (idx == 4'd15) begin
                    pat  <= '0;
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                    PASS <= (errcnt_nx == 5'd0);
                end else begin
                    idx <= idx + 4'd1;
                    pat <= idx + 4'd1;
                end
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule
